tohost_uart_reporter: RTL

//  Consumes the 32-bit tohost word from the data-memory model and reports the test result on a UART line.

---
 rtl/tohost_uart_reporter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tohost_uart_reporter.sv
// tohost_uart_reporter: latches the first nonzero tohost word and reports PASS/FAIL over 8N1 UART
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-low reset
//   tohost   in   [31:0] tohost word from the data-memory model
//   uart_tx  out  serial line, idle high, LSB first
//   busy     out  message in flight
//   done     out  nonzero tohost latched (sticky)
//   pass     out  latched value == 1
//   result   out  [31:0] latched tohost value
module tohost_uart_reporter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] tohost,
    output logic        uart_tx,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] result
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, HALT} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [31:0]   result_q, result_d;

    logic [2:0] nsel;
    logic [3:0] nib;
    logic [7:0] hex;
    logic [7:0] ch;
    logic [3:0] msg_last;
    logic       tick;

    // Hex digits of result run MSB nibble first from index 5; (12 - idx) mod 8 picks the nibble.
    always_comb begin
        nsel = 3'd4 - idx_q[2:0];
        nib  = 4'(result_q >> {nsel, 2'b00});
        hex  = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
        ch   = hex;
        if (pass_q) begin
            case (idx_q)
                4'd0:    ch = 8'h50;
                4'd1:    ch = 8'h41;
                4'd2:    ch = 8'h53;
                4'd3:    ch = 8'h53;
                4'd4:    ch = 8'h0D;
                default: ch = 8'h0A;
            endcase
        end else begin
            case (idx_q)
                4'd0:    ch = 8'h46;
                4'd1:    ch = 8'h41;
                4'd2:    ch = 8'h49;
                4'd3:    ch = 8'h4C;
                4'd4:    ch = 8'h20;
                4'd13:   ch = 8'h0D;
                4'd14:   ch = 8'h0A;
                default: ch = hex;
            endcase
        end
    end

    assign msg_last = pass_q ? 4'd5 : 4'd14;
    assign tick     = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        done_d   = done_q;
        pass_d   = pass_q;
        result_d = result_q;
        // Line level follows the current state, so it lags the state register by one edge.
        tx_d     = (state_q == START) ? 1'b0 : (state_q == DATA) ? ch[bit_q] : 1'b1;
        case (state_q)
            IDLE: begin
                if (!done_q && tohost != 32'h0) begin
                    result_d = tohost;
                    done_d   = 1'b1;
                    pass_d   = (tohost == 32'h1);
                    baud_d   = '0;
                    bit_d    = '0;
                    idx_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                baud_d = tick ? '0 : baud_q + 1'b1;
                if (tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = tick ? '0 : baud_q + 1'b1;
                if (tick) begin
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                baud_d = tick ? '0 : baud_q + 1'b1;
                if (tick) begin
                    idx_d   = (idx_q == msg_last) ? idx_q : idx_q + 4'd1;
                    state_d = (idx_q == msg_last) ? HALT : START;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            result_q <= result_d;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = (state_q != IDLE) && (state_q != HALT);
    assign done    = done_q;
    assign pass    = pass_q;
    assign result  = result_q;
endmodule
